// File: rtl/t5_wbarb_pkg.sv
// Shared encodings for the t5_wbarb instruction/data Wishbone arbiter.
// The state codes equal the arb_gnt codes so the grant status is the state register.
package t5_wbarb_pkg;

  localparam logic [1:0] ARB_GNT_NONE = 2'b00;
  localparam logic [1:0] ARB_GNT_I    = 2'b01;
  localparam logic [1:0] ARB_GNT_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ARB_GNT_NONE,
    GNT_I = ARB_GNT_I,
    GNT_D = ARB_GNT_D
  } arb_state_t;

endpackage

// File: rtl/t5_wbarb_rr.sv
// Round-robin pick between the instruction and data requesters.
// Holds the last-grant flag, which is updated whenever a grant is taken from idle.
module t5_wbarb_rr
  import t5_wbarb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       take,
  output logic [1:0] win
);

  logic last_d;

  // On contention the side that did not win last time gets the port
  always_comb begin
    win = ARB_GNT_NONE;
    if (req_i && req_d)
      win = last_d ? ARB_GNT_I : ARB_GNT_D;
    else if (req_d)
      win = ARB_GNT_D;
    else if (req_i)
      win = ARB_GNT_I;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      last_d <= 1'b0;
    else if (take && (win != ARB_GNT_NONE))
      last_d <= (win == ARB_GNT_D);
  end

endmodule

// File: rtl/t5_wbarb.sv
// Two-to-one Wishbone arbiter sharing one classic single-beat port between iwb and dwb.
// Optional ack watchdog with arb_err pulse is built when T5_WBARB_TIMEOUT_EN is defined.
module t5_wbarb
  import t5_wbarb_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned TOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          iwb_stb,
  input  logic          iwb_wre,
  input  logic [3:0]    iwb_sel,
  input  logic [29:0]   iwb_adr,
  output logic          iwb_ack,
  output logic [DW-1:0] iwb_dat,
  input  logic          dwb_stb,
  input  logic          dwb_wre,
  input  logic [3:0]    dwb_sel,
  input  logic [29:0]   dwb_adr,
  input  logic [DW-1:0] dwb_dto,
  output logic          dwb_ack,
  output logic [DW-1:0] dwb_dti,
  output logic          mwb_stb,
  output logic          mwb_wre,
  output logic [3:0]    mwb_sel,
  output logic [29:0]   mwb_adr,
  output logic [DW-1:0] mwb_dto,
  input  logic [DW-1:0] mwb_dti,
  input  logic          mwb_ack,
  output logic [1:0]    arb_gnt,
  output logic          arb_err
);

  arb_state_t state_q, state_d;
  logic [1:0] rr_win;
  logic       tout_hit;

  t5_wbarb_rr u_rr (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_i     (iwb_stb),
    .req_d     (dwb_stb),
    .take      (state_q == IDLE),
    .win       (rr_win)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Port muxing is purely a function of the registered grant, so reset clears it at once
  always_comb begin
    state_d = state_q;
    mwb_stb = 1'b0;
    mwb_wre = 1'b0;
    mwb_sel = '0;
    mwb_adr = '0;
    mwb_dto = '0;
    iwb_ack = 1'b0;
    iwb_dat = '0;
    dwb_ack = 1'b0;
    dwb_dti = '0;
    case (state_q)
      IDLE: begin
        state_d = arb_state_t'(rr_win);
      end
      GNT_I: begin
        mwb_stb = iwb_stb & ~tout_hit;
        mwb_wre = iwb_wre;
        mwb_sel = iwb_sel;
        mwb_adr = iwb_adr;
        iwb_ack = mwb_ack | tout_hit;
        iwb_dat = tout_hit ? '0 : mwb_dti;
        if (mwb_ack || !iwb_stb || tout_hit)
          state_d = IDLE;
      end
      GNT_D: begin
        mwb_stb = dwb_stb & ~tout_hit;
        mwb_wre = dwb_wre;
        mwb_sel = dwb_sel;
        mwb_adr = dwb_adr;
        mwb_dto = dwb_dto;
        dwb_ack = mwb_ack | tout_hit;
        dwb_dti = tout_hit ? '0 : mwb_dti;
        if (mwb_ack || !dwb_stb || tout_hit)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign arb_gnt = state_q;

`ifdef T5_WBARB_TIMEOUT_EN
  localparam logic [7:0] TOUT_LIM = 8'(TOUT);
  logic [7:0] tout_cnt;

  // Counts granted cycles without ack; idle keeps it at zero so each grant starts fresh
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      tout_cnt <= '0;
    else if (state_q == IDLE)
      tout_cnt <= '0;
    else if (!mwb_ack && !tout_hit)
      tout_cnt <= tout_cnt + 8'd1;
  end

  assign tout_hit = (state_q != IDLE) && !mwb_ack && (tout_cnt == TOUT_LIM);
  assign arb_err  = tout_hit;
`else
  // TOUT only has meaning for the watchdog build
  if (TOUT == 0) begin : g_tout_unused
  end
  assign tout_hit = 1'b0;
  assign arb_err  = 1'b0;
`endif

endmodule

// File: tb/tb_t5_wbarb.sv
// Directed scoreboard bench for t5_wbarb; expected acks are queued by the stimulus
// and popped by an independent monitor whenever either requester sees an ack.
module tb_t5_wbarb;
  import t5_wbarb_pkg::*;

  localparam int unsigned DW = 32;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          iwb_stb, iwb_wre;
  logic [3:0]    iwb_sel;
  logic [29:0]   iwb_adr;
  logic          iwb_ack;
  logic [DW-1:0] iwb_dat;
  logic          dwb_stb, dwb_wre;
  logic [3:0]    dwb_sel;
  logic [29:0]   dwb_adr;
  logic [DW-1:0] dwb_dto;
  logic          dwb_ack;
  logic [DW-1:0] dwb_dti;
  logic          mwb_stb, mwb_wre;
  logic [3:0]    mwb_sel;
  logic [29:0]   mwb_adr;
  logic [DW-1:0] mwb_dto;
  logic [DW-1:0] mwb_dti;
  logic          mwb_ack;
  logic [1:0]    arb_gnt;
  logic          arb_err;

  typedef struct {
    logic        port_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  t5_wbarb #(.DW(DW), .TOUT(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .iwb_stb   (iwb_stb),
    .iwb_wre   (iwb_wre),
    .iwb_sel   (iwb_sel),
    .iwb_adr   (iwb_adr),
    .iwb_ack   (iwb_ack),
    .iwb_dat   (iwb_dat),
    .dwb_stb   (dwb_stb),
    .dwb_wre   (dwb_wre),
    .dwb_sel   (dwb_sel),
    .dwb_adr   (dwb_adr),
    .dwb_dto   (dwb_dto),
    .dwb_ack   (dwb_ack),
    .dwb_dti   (dwb_dti),
    .mwb_stb   (mwb_stb),
    .mwb_wre   (mwb_wre),
    .mwb_sel   (mwb_sel),
    .mwb_adr   (mwb_adr),
    .mwb_dto   (mwb_dto),
    .mwb_dti   (mwb_dti),
    .mwb_ack   (mwb_ack),
    .arb_gnt   (arb_gnt),
    .arb_err   (arb_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic i_stb, input logic d_stb, input logic d_wre,
                               input logic ack, input logic [31:0] dti);
    iwb_stb = i_stb;
    dwb_stb = d_stb;
    dwb_wre = d_wre;
    mwb_ack = ack;
    mwb_dti = dti;
  endtask

  // push: 0 none, 1 instruction ack, 2 data ack, 3 data watchdog ack
  task automatic stepCycle(input logic i_stb, input logic d_stb, input logic d_wre,
                           input logic ack, input logic [31:0] dti, input int push,
                           input logic [1:0] exp_gnt, input logic exp_stb);
    exp_t e;
    @(posedge sys_clk);
    #1;
    applyStimulus(i_stb, d_stb, d_wre, ack, dti);
    if (push != 0) begin
      e.port_d = (push != 1);
      e.data   = (push == 3) ? 32'h0 : dti;
      e.err    = (push == 3);
      exp_q.push_back(e);
    end
    #2;
    checkOutput("arb_gnt", 32'(arb_gnt), 32'(exp_gnt));
    checkOutput("mwb_stb", 32'(mwb_stb), 32'(exp_stb));
  endtask

  task automatic applyReset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("rst_arb_gnt", 32'(arb_gnt), 32'(ARB_GNT_NONE));
    checkOutput("rst_mwb_stb", 32'(mwb_stb), 32'h0);
    checkOutput("rst_acks", 32'({iwb_ack, dwb_ack}), 32'h0);
    checkOutput("rst_arb_err", 32'(arb_err), 32'h0);
    checkOutput("rst_mwb_adr", 32'(mwb_adr), 32'h0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every ack seen mid-cycle must match the oldest queued expectation
  initial begin
    exp_t e;
    logic [31:0] got_data;
    forever begin
      @(negedge sys_clk);
      if (iwb_ack || dwb_ack) begin
        n_checks++;
        got_data = dwb_ack ? dwb_dti : iwb_dat;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("[TB] FAIL unexpected_ack: iwb_ack=%0b dwb_ack=%0b, expected no ack at %0t",
                   iwb_ack, dwb_ack, $time);
        end else begin
          e = exp_q.pop_front();
          if ((iwb_ack && dwb_ack) || (dwb_ack != e.port_d) || (got_data != e.data) ||
              (arb_err != e.err)) begin
            n_fails++;
            $display("[TB] FAIL ack_route: got iwb_ack=%0b dwb_ack=%0b data=0x%0h err=%0b, expected port_d=%0b data=0x%0h err=%0b at %0t",
                     iwb_ack, dwb_ack, got_data, arb_err, e.port_d, e.data, e.err, $time);
          end
        end
      end else if (arb_err) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL arb_err_alone: got 1, expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    sys_rst_n = 1'b0;
    iwb_wre   = 1'b0;
    iwb_sel   = 4'hF;
    iwb_adr   = 30'h040;
    dwb_sel   = 4'h3;
    dwb_adr   = 30'h100;
    dwb_dto   = 32'h55AA0001;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] lone data request");
    applyReset();
    stepCycle(0, 1, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(0, 1, 0, 0, 32'h0, 0, ARB_GNT_D, 1);
    checkOutput("d_mwb_adr", 32'(mwb_adr), 32'h100);
    checkOutput("d_mwb_sel", 32'(mwb_sel), 32'h3);
    checkOutput("d_mwb_dto", mwb_dto, 32'h55AA0001);
    stepCycle(0, 1, 0, 0, 32'h0, 0, ARB_GNT_D, 1);
    stepCycle(0, 1, 0, 1, 32'hCAFE0001, 2, ARB_GNT_D, 1);
    checkOutput("d_iwb_ack_quiet", 32'(iwb_ack), 32'h0);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);

    $display("[TB] contention after reset");
    applyReset();
    stepCycle(1, 1, 1, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(1, 1, 1, 1, 32'hD0000001, 2, ARB_GNT_D, 1);
    checkOutput("c_mwb_wre_d", 32'(mwb_wre), 32'h1);
    checkOutput("c_mwb_adr_d", 32'(mwb_adr), 32'h100);
    stepCycle(1, 1, 1, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(1, 1, 1, 1, 32'h00000013, 1, ARB_GNT_I, 1);
    checkOutput("c_mwb_adr_i", 32'(mwb_adr), 32'h040);
    checkOutput("c_mwb_wre_i", 32'(mwb_wre), 32'h0);
    checkOutput("c_mwb_sel_i", 32'(mwb_sel), 32'hF);
    checkOutput("c_mwb_dto_i", mwb_dto, 32'h0);
    checkOutput("c_iwb_dat", iwb_dat, 32'h00000013);
    checkOutput("c_dwb_dti_zero", dwb_dti, 32'h0);
    stepCycle(1, 1, 1, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(1, 1, 1, 1, 32'hD0000002, 2, ARB_GNT_D, 1);
    checkOutput("c_iwb_dat_zero", iwb_dat, 32'h0);
    stepCycle(1, 1, 1, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(1, 1, 1, 1, 32'h00100073, 1, ARB_GNT_I, 1);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);

    $display("[TB] abort and stray ack");
    applyReset();
    stepCycle(0, 1, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(0, 1, 0, 0, 32'h0, 0, ARB_GNT_D, 1);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_D, 0);
    stepCycle(0, 0, 0, 1, 32'hDEADBEEF, 0, ARB_GNT_NONE, 0);
    checkOutput("stray_acks", 32'({iwb_ack, dwb_ack}), 32'h0);
    checkOutput("stray_dti", dwb_dti, 32'h0);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);

    $display("[TB] async reset mid-transfer");
    applyReset();
    stepCycle(1, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    stepCycle(1, 0, 0, 0, 32'h0, 0, ARB_GNT_I, 1);
    @(posedge sys_clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h5);
    #1;
    checkOutput("pre_rst_iwb_ack", 32'(iwb_ack), 32'h1);
    #1;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_mwb_stb", 32'(mwb_stb), 32'h0);
    checkOutput("async_iwb_ack", 32'(iwb_ack), 32'h0);
    checkOutput("async_arb_gnt", 32'(arb_gnt), 32'(ARB_GNT_NONE));
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
    #2;
    checkOutput("post_rst_stray_acks", 32'({iwb_ack, dwb_ack}), 32'h0);
    checkOutput("post_rst_arb_gnt", 32'(arb_gnt), 32'(ARB_GNT_NONE));
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);

    $display("[TB] slave never acks");
    applyReset();
    stepCycle(0, 1, 0, 0, 32'hBADBAD00, 0, ARB_GNT_NONE, 0);
`ifdef T5_WBARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++)
      stepCycle(0, 1, 0, 0, 32'hBADBAD00, 0, ARB_GNT_D, 1);
    stepCycle(0, 1, 0, 0, 32'hBADBAD00, 3, ARB_GNT_D, 0);
    checkOutput("tout_arb_err", 32'(arb_err), 32'h1);
    checkOutput("tout_dwb_dti", dwb_dti, 32'h0);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);
    checkOutput("tout_err_clear", 32'(arb_err), 32'h0);
`else
    for (int i = 0; i < 8; i++)
      stepCycle(0, 1, 0, 0, 32'hBADBAD00, 0, ARB_GNT_D, 1);
    checkOutput("hold_arb_err", 32'(arb_err), 32'h0);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_D, 0);
    stepCycle(0, 0, 0, 0, 32'h0, 0, ARB_GNT_NONE, 0);
`endif

    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/t5_wbarb.md
Name: t5_wbarb

Overview:
Two-to-one Wishbone arbiter that shares one external memory port between the core's instruction bus (iwb_*) and data bus (dwb_*). It sits between t5_rv32i and a unified memory or slave fabric. It issues one classic single-beat cycle at a time and uses round-robin fairness when both buses request together. It routes the ack and read data back to the requester that holds the grant.

Parameters:
DW, 32, data width of all data buses
TOUT, 255, ack watchdog limit in cycles (used only with T5_WBARB_TIMEOUT_EN), 8-bit range

Ports:
sys_clk  input  1  system clock, rising edge
sys_rst_n  input  1  asynchronous, active-low reset
iwb_stb  input  1  instruction request strobe
iwb_wre  input  1  instruction write enable (normally 0)
iwb_sel  input  4  instruction byte selects
iwb_adr  input  30  instruction word address [31:2]
iwb_ack  output  1  instruction ack
iwb_dat  output  DW  instruction read data
dwb_stb  input  1  data request strobe
dwb_wre  input  1  data write enable
dwb_sel  input  4  data byte selects
dwb_adr  input  30  data word address [31:2]
dwb_dto  input  DW  data write data
dwb_ack  output  1  data ack
dwb_dti  output  DW  data read data
mwb_stb  output  1  shared port strobe
mwb_wre  output  1  shared port write enable
mwb_sel  output  4  shared port byte selects
mwb_adr  output  30  shared port word address
mwb_dto  output  DW  shared port write data
mwb_dti  input  DW  shared port read data
mwb_ack  input  1  shared port ack
arb_gnt  output  2  grant status: 00 idle, 01 instruction, 10 data
arb_err  output  1  one-cycle timeout pulse (optional feature only)

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst_n is asynchronous and active-low.
- State machine: IDLE, GNT_I, GNT_D. State is registered. Reset state is IDLE, and the last-grant flag resets to "instruction".
- Reset values: mwb_stb=0, iwb_ack=0, dwb_ack=0, arb_gnt=00, arb_err=0. mwb_adr, mwb_sel, mwb_wre and mwb_dto are 0 in IDLE.
- Transitions out of IDLE:
  - Only iwb_stb high: go to GNT_I.
  - Only dwb_stb high: go to GNT_D.
  - Both high: grant the port that was not granted last. The first contention after reset therefore goes to data.
  - Neither high: stay in IDLE.
- Transitions out of GNT_x:
  - mwb_ack=1: go to IDLE.
  - Granted stb drops with no ack (abort): go to IDLE next cycle.
  - Otherwise hold the grant. Grants are never preempted.
- Latency: a request seen at edge N produces mwb_stb high in cycle N+1. Every transfer is followed by one mandatory IDLE cycle, so one port gets at most one transfer every 2 cycles plus slave latency.
- Muxing while granted (combinational): mwb_stb = granted stb. mwb_adr, sel, wre and dto come from the granted port; iwb has no write data, so mwb_dto=0 under an instruction grant.
- Ack and read data: granted ack = mwb_ack in the same cycle. The granted read data bus = mwb_dti. The ungranted ack is always 0, and the ungranted read data is 0.
- mwb_ack in IDLE: stray ack, ignored, not forwarded to either port.
- arb_gnt reflects the registered state.
- Reset mid-cycle: everything clears immediately. Any later slave ack is treated as a stray ack.

Optional Feature:
- Macro: T5_WBARB_TIMEOUT_EN.
- With the macro: an 8-bit counter clears on entry to GNT_x and increments each granted cycle without ack. When it reaches TOUT:
  - Force a one-cycle ack to the granted requester, with read data 0.
  - Pulse arb_err for that cycle.
  - Go to IDLE and drop mwb_stb.
- Without the macro: no counter. arb_err is tied to 0 and a grant waits for ack indefinitely.

Decomposition:
- Shared package or include t5_defs: state encodings (IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10) and the arb_gnt codes, so arb_gnt directly equals the state.
- One natural sub-module, t5_wbarb_rr: the round-robin pick. Inputs are two requests and the last-grant flag; output is the winner. It also updates the last-grant flag on each grant.

Test Plan:
- Lone data request: dwb_stb=1, adr=30'h100, slave acks 2 cycles after mwb_stb -> mwb_stb rises 1 cycle after request, mwb_adr=30'h100, dwb_ack pulses together with mwb_ack, iwb_ack stays 0, arb_gnt sequence 00,10,10,10,00.
- Contention after reset: iwb_stb and dwb_stb high in the same cycle and held -> data granted first; after its ack and the IDLE cycle, instruction is granted; grants alternate D,I,D,I over 4 transfers.
- Read data routing: instruction grant with mwb_dti=32'h00000013 -> iwb_dat=32'h00000013, dwb_dti=0.
- Abort and stray ack: granted dwb_stb drops before ack -> IDLE next cycle; then mwb_ack=1 in IDLE -> no ack on either port.
- Async reset mid-transfer: sys_rst_n low while in GNT_I -> mwb_stb, iwb_ack and arb_gnt are 0 immediately, without waiting for a clock edge.
- Timeout (macro defined, TOUT=4): slave never acks -> after 4 granted cycles, requester ack=1 with data 0, arb_err pulses once, state returns to IDLE.
